// File: rtl/avalon_multi_timer.sv
// avalon_multi_timer: NUM_CH independent CNT_W-bit down-counting interval timers behind a 32-bit Avalon-MM slave.
// Latency: readdata registered, valid 1 clk after address; writes take effect on the clk edge they are presented.
// Backpressure: none, every access completes in one clk (no waitrequest). Optional macro TIMER_PRESCALER_EN adds an 8-bit prescaler per channel.
module avalon_multi_timer #(
    parameter  int CH_AW        = 2,
    parameter  int CNT_W        = 32,
    parameter  int RESET_PERIOD = 49999,
    localparam int NUM_CH       = 2 ** CH_AW
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CH_AW+1:0]    address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [NUM_CH-1:0]   irq_ch,
    output logic                irq
);

    localparam logic [CNT_W-1:0] RST_VAL     = CNT_W'(RESET_PERIOD);
    localparam logic [1:0]       REG_STATUS  = 2'd0;
    localparam logic [1:0]       REG_CONTROL = 2'd1;
    localparam logic [1:0]       REG_PERIOD  = 2'd2;

    logic                       wr_en;
    logic [1:0]                 reg_sel;
    logic [CH_AW+1:0]           ch_sel;
    logic [NUM_CH-1:0][31:0]    rd_word;
    logic [31:0]                rd_mux;

    assign wr_en   = chipselect && !write_n;
    assign reg_sel = address[1:0];
    assign ch_sel  = address >> 2;

    genvar n;
    generate
        for (n = 0; n < NUM_CH; n++) begin : g_ch
            logic               hit;
            logic               wr_ch;
            logic               tick;
            logic               expire;
            logic [CNT_W-1:0]   cnt;
            logic [CNT_W-1:0]   period;
            logic [CNT_W-1:0]   snap;
            logic               run;
            logic               to_flag;
            logic               ito;
            logic               cont;
            logic               start_bit;
            logic               stop_bit;
            logic [7:0]         presc;
            logic [31:0]        word;

            assign hit    = (ch_sel == (CH_AW+2)'(n));
            assign wr_ch  = wr_en && hit;
            // A timeout in the same clk as a STATUS write must keep TO set
            assign expire = run && tick && (cnt == '0);

`ifdef TIMER_PRESCALER_EN
            logic [7:0] pcnt;
            assign tick = (pcnt == presc);

            // Prescaler phase restarts on START or PERIOD write and only advances while running
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pcnt <= '0;
                end else if (wr_ch && ((reg_sel == REG_CONTROL && writedata[2]) || reg_sel == REG_PERIOD)) begin
                    pcnt <= '0;
                end else if (run) begin
                    pcnt <= tick ? 8'd0 : pcnt + 8'd1;
                end
            end
`else
            assign tick  = 1'b1;
            assign presc = 8'd0;
`endif

            // Counter, status and register file; bus writes override the counting update
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt       <= RST_VAL;
                    period    <= RST_VAL;
                    snap      <= '0;
                    run       <= 1'b0;
                    to_flag   <= 1'b0;
                    ito       <= 1'b0;
                    cont      <= 1'b0;
                    start_bit <= 1'b0;
                    stop_bit  <= 1'b0;
`ifdef TIMER_PRESCALER_EN
                    presc     <= '0;
`endif
                end else begin
                    if (run && tick) begin
                        if (cnt != '0) begin
                            cnt <= cnt - CNT_W'(1);
                        end else begin
                            cnt     <= period;
                            to_flag <= 1'b1;
                            if (!cont) begin
                                run <= 1'b0;
                            end
                        end
                    end
                    if (wr_ch) begin
                        case (reg_sel)
                            REG_STATUS: begin
                                to_flag <= expire;
                            end
                            REG_CONTROL: begin
                                ito       <= writedata[0];
                                cont      <= writedata[1];
                                start_bit <= writedata[2];
                                stop_bit  <= writedata[3];
`ifdef TIMER_PRESCALER_EN
                                presc     <= writedata[15:8];
`endif
                                if (writedata[2]) begin
                                    run <= 1'b1;
                                end else if (writedata[3]) begin
                                    run <= 1'b0;
                                end
                            end
                            REG_PERIOD: begin
                                period <= writedata[CNT_W-1:0];
                                cnt    <= writedata[CNT_W-1:0];
                                run    <= 1'b0;
                            end
                            default: begin
                                // Captures the counter as it was before this edge's update
                                snap <= cnt;
                            end
                        endcase
                    end
                end
            end

            // Per-channel read word for the selected register, unused bits zero
            always_comb begin
                word = '0;
                case (reg_sel)
                    REG_STATUS: begin
                        word[1:0] = {run, to_flag};
                    end
                    REG_CONTROL: begin
                        word[3:0]  = {stop_bit, start_bit, cont, ito};
                        word[15:8] = presc;
                    end
                    REG_PERIOD: begin
                        word[CNT_W-1:0] = period;
                    end
                    default: begin
                        word[CNT_W-1:0] = snap;
                    end
                endcase
            end

            assign rd_word[n] = word;
            assign irq_ch[n]  = to_flag && ito;
        end
    endgenerate

    // Select the addressed channel's read word
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == (CH_AW+2)'(i)) begin
                rd_mux = rd_word[i];
            end
        end
    end

    // Registered read path, refreshed every clk regardless of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |irq_ch;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Testbench for avalon_multi_timer: directed scenarios plus randomized channel runs.
// Expected values come from a closed-form model (counter value after k ticks from START).
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_avalon_multi_timer;

    localparam int CH_AW  = 2;
    localparam int NUM_CH = 4;
    localparam int RP     = 49999;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [CH_AW+1:0]    address;
    logic                chipselect;
    logic                write_n;
    logic [31:0]         writedata;
    logic [31:0]         readdata;
    logic [NUM_CH-1:0]   irq_ch;
    logic                irq;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int es1    = 0;

    avalon_multi_timer #(.CH_AW(CH_AW), .CNT_W(32), .RESET_PERIOD(RP)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_ch     (irq_ch),
        .irq        (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: counter value k ticks after a START with counter = period = p
    function automatic int model_cnt(input int p, input bit cont, input int k);
        if (k <= p) return p - k;
        if (!cont) return p;
        return p - ((k - p - 1) % (p + 1));
    endfunction

    function automatic bit model_to(input int p, input int k);
        return k >= p + 1;
    endfunction

    function automatic bit model_run(input int p, input bit cont, input int k);
        return cont || (k < p + 1);
    endfunction

    // Write; e = index of the edge where the write takes effect
    task automatic wr(input int ch, input int r, input logic [31:0] d, output int e);
        @(negedge clk);
        address    = 4'(ch * 4 + r);
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(posedge clk);
        #1;
        e          = cyc;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Read; d reflects state after edge e-1
    task automatic rd(input int ch, input int r, output logic [31:0] d, output int e);
        @(negedge clk);
        address    = 4'(ch * 4 + r);
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(posedge clk);
        #1;
        d          = readdata;
        e          = cyc;
        chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int e;
        reset_n = 1'b0;
        #1;
        checks++;
        if (readdata !== 32'd0 || irq_ch !== 4'd0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: readdata=%0h irq_ch=%b irq=%b, expected 0", readdata, irq_ch, irq);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rd(0, 2, d, e);
        checks++;
        if (d !== 32'(RP)) begin errors++; $display("FAIL reset_period: got %0d expected %0d", d, RP); end
        rd(0, 0, d, e);
        checks++;
        if (d !== 32'd0 || irq !== 1'b0) begin errors++; $display("FAIL reset_status: got %0h irq=%b expected 0", d, irq); end
        rd(0, 1, d, e);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_control: got %0h expected 0", d); end
        rd(3, 3, d, e);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_snap: got %0h expected 0", d); end
        // Read path updates without chipselect
        @(negedge clk);
        address = 4'(2 * 4 + 2);
        @(posedge clk);
        #1;
        checks++;
        if (readdata !== 32'(RP)) begin errors++; $display("FAIL read_no_cs: got %0d expected %0d", readdata, RP); end
    endtask

    task automatic test_continuous();
        int e, es, ec, nx;
        bit ex;
        wr(1, 2, 32'd4, e);
        wr(1, 1, 32'h7, es);
        es1 = es;
        for (int i = 0; i < 13; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            ex = model_to(4, cyc - es);
            checks++;
            if (irq_ch[1] !== ex || irq !== ex) begin
                errors++;
                $display("FAIL cont_irq at start+%0d: irq_ch1=%b irq=%b expected %b", cyc - es, irq_ch[1], irq, ex);
            end
        end
        wr(1, 0, 32'd0, ec);
        nx = es + 5 * ((ec - es + 4) / 5);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            ex = (cyc >= nx);
            checks++;
            if (irq_ch[1] !== ex || irq !== ex) begin
                errors++;
                $display("FAIL cont_clear at start+%0d: irq_ch1=%b irq=%b expected %b", cyc - es, irq_ch[1], irq, ex);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        int e, es;
        bit ex;
        wr(2, 2, 32'd3, e);
        wr(2, 1, 32'h5, es);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            ex = model_to(3, cyc - es);
            checks++;
            if (irq_ch[2] !== ex) begin
                errors++;
                $display("FAIL oneshot_irq at start+%0d: irq_ch2=%b expected %b", cyc - es, irq_ch[2], ex);
            end
        end
        rd(2, 0, d, e);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL oneshot_status: got %0h expected 1", d); end
        wr(2, 3, 32'd0, e);
        rd(2, 3, d, e);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL oneshot_hold: got %0d expected 3", d); end
    endtask

    task automatic test_snapshot();
        logic [31:0] d;
        int e, es, ew;
        int ex;
        wr(0, 2, 32'd100, e);
        wr(0, 1, 32'h6, es);
        repeat (10) @(posedge clk);
        wr(0, 3, 32'd0, ew);
        ex = model_cnt(100, 1'b1, ew - 1 - es);
        rd(0, 3, d, e);
        checks++;
        if (d !== 32'(ex)) begin errors++; $display("FAIL snap_first: got %0d expected %0d", d, ex); end
        repeat (7) @(posedge clk);
        wr(0, 3, 32'd0, ew);
        ex = model_cnt(100, 1'b1, ew - 1 - es);
        rd(0, 3, d, e);
        checks++;
        if (d !== 32'(ex)) begin errors++; $display("FAIL snap_second: got %0d expected %0d", d, ex); end
        rd(0, 0, d, e);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL snap_status: got %0h expected 2", d); end
        rd(3, 0, d, e);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL ch3_status: got %0h expected 0", d); end
        rd(3, 2, d, e);
        checks++;
        if (d !== 32'(RP)) begin errors++; $display("FAIL ch3_period: got %0d expected %0d", d, RP); end
        wr(3, 3, 32'd0, e);
        rd(3, 3, d, e);
        checks++;
        if (d !== 32'(RP)) begin errors++; $display("FAIL ch3_snap: got %0d expected %0d", d, RP); end
    endtask

    task automatic test_to_race();
        logic [31:0] d;
        int e, x, guard;
        x = es1 + 5 * ((cyc + 2 - es1 + 4) / 5);
        guard = 0;
        while (cyc < x - 1 && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        wr(1, 0, 32'd0, e);
        checks++;
        if (e !== x) begin errors++; $display("FAIL race_align: write edge %0d expected %0d", e, x); end
        rd(1, 0, d, e);
        checks++;
        if (d !== 32'h3 || irq_ch[1] !== 1'b1) begin
            errors++;
            $display("FAIL race_to: status %0h irq_ch1=%b expected 3 and 1", d, irq_ch[1]);
        end
        wr(1, 1, 32'hC, e);
        rd(1, 0, d, e);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL start_stop: status %0h expected 3", d); end
        rd(1, 1, d, e);
        checks++;
        if (d !== 32'hC) begin errors++; $display("FAIL ctrl_readback: got %0h expected c", d); end
    endtask

    task automatic test_prescaler();
        logic [31:0] d;
        int e, es;
`ifdef TIMER_PRESCALER_EN
        int ec, nx;
        bit ex;
        wr(2, 2, 32'd2, e);
        wr(2, 0, 32'd0, e);
        wr(2, 1, 32'h0307, es);
        for (int i = 0; i < 14; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            ex = (cyc - es >= 12);
            checks++;
            if (irq_ch[2] !== ex) begin
                errors++;
                $display("FAIL presc_irq at start+%0d: irq_ch2=%b expected %b", cyc - es, irq_ch[2], ex);
            end
        end
        wr(2, 0, 32'd0, ec);
        nx = es + 12 * ((ec - es + 11) / 12);
        for (int i = 0; i < 13; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            ex = (cyc >= nx);
            checks++;
            if (irq_ch[2] !== ex) begin
                errors++;
                $display("FAIL presc_repeat at start+%0d: irq_ch2=%b expected %b", cyc - es, irq_ch[2], ex);
            end
        end
        rd(2, 1, d, e);
        checks++;
        if (d !== 32'h0307) begin errors++; $display("FAIL presc_ctrl: got %0h expected 307", d); end
`else
        wr(2, 1, 32'h0307, es);
        rd(2, 1, d, e);
        checks++;
        if (d !== 32'h0007) begin errors++; $display("FAIL presc_ctrl: got %0h expected 7", d); end
`endif
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        int e;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (readdata !== 32'd0 || irq !== 1'b0 || irq_ch !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: readdata=%0h irq=%b irq_ch=%b expected 0", readdata, irq, irq_ch);
        end
        @(negedge clk);
        reset_n = 1'b1;
        rd(0, 0, d, e);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL arst_status: got %0h expected 0", d); end
        repeat (5) @(posedge clk);
        wr(0, 3, 32'd0, e);
        rd(0, 3, d, e);
        checks++;
        if (d !== 32'(RP)) begin errors++; $display("FAIL arst_no_count: got %0d expected %0d", d, RP); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        int e, es, ew, er, ch, p, w, ex;
        bit cont, exr, ext;
        for (int it = 0; it < 10; it++) begin
            ch   = int'($urandom_range(0, 3));
            p    = int'($urandom_range(0, 7));
            cont = 1'($urandom_range(0, 1));
            w    = int'($urandom_range(0, 20));
            wr(ch, 2, 32'(p), e);
            wr(ch, 0, 32'd0, e);
            wr(ch, 1, 32'(5 + (cont ? 2 : 0)), es);
            repeat (w) @(posedge clk);
            wr(ch, 3, 32'd0, ew);
            ex = model_cnt(p, cont, ew - 1 - es);
            rd(ch, 3, d, er);
            checks++;
            if (d !== 32'(ex)) begin
                errors++;
                $display("FAIL rand_snap it%0d ch%0d p%0d cont%0b: got %0d expected %0d", it, ch, p, cont, d, ex);
            end
            rd(ch, 0, d, er);
            exr = model_run(p, cont, er - 1 - es);
            ext = model_to(p, er - 1 - es);
            checks++;
            if (d !== {30'd0, exr, ext}) begin
                errors++;
                $display("FAIL rand_status it%0d ch%0d p%0d cont%0b: got %0h expected %0h", it, ch, p, cont, d, {exr, ext});
            end
            ext = model_to(p, er - es);
            checks++;
            if (irq_ch[ch] !== ext) begin
                errors++;
                $display("FAIL rand_irq it%0d ch%0d: got %b expected %b", it, ch, irq_ch[ch], ext);
            end
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        test_reset();
        test_continuous();
        test_oneshot();
        test_snapshot();
        test_to_race();
        test_prescaler();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
